// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and defaults for the writeback port arbiter and its late-result FIFO.
package wb_port_arbiter_pkg;

  localparam int unsigned WB_XLEN       = 32;
  localparam int unsigned WB_LATE_DEPTH = 4;
  localparam int unsigned WB_STARVE_MAX = 8;

  typedef struct packed {
    logic               live;
    logic [4:0]         rd;
    logic [WB_XLEN-1:0] data;
  } wb_late_entry_t;

endpackage

// File: rtl/wb_late_fifo.sv
// Circular buffer of late results with a parallel WAW kill port and two rd-match search ports.
module wb_late_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = WB_LATE_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  wb_late_entry_t             push_entry,
  input  logic                       pop,
  input  logic                       kill_en,
  input  logic [4:0]                 kill_rd,
  input  logic [4:0]                 rs1,
  input  logic [4:0]                 rs2,
  output wb_late_entry_t             head,
  output logic                       head_valid,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       rs1_match,
  output logic                       rs2_match
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  wb_late_entry_t  mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;

  // Payload storage carries no reset; valid_q alone defines occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (kill_en && valid_q[i] && (mem_q[i].rd == kill_rd)) begin
          mem_q[i].live <= 1'b0;
        end
      end
      if (pop) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + 1'b1;
      end
      if (push) begin
        mem_q[wr_ptr_q]   <= push_entry;
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    rs1_match = 1'b0;
    rs2_match = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && mem_q[i].live) begin
        if (mem_q[i].rd == rs1) rs1_match = 1'b1;
        if (mem_q[i].rd == rs2) rs2_match = 1'b1;
      end
    end
  end

  assign head       = mem_q[rd_ptr_q];
  assign head_valid = valid_q[rd_ptr_q];
  assign full       = (count_q == CntW'(DEPTH));
  assign count      = count_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter: pipeline writeback vs buffered late results,
// with RAW-pending flags and a starvation-driven one-cycle drain stall.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned XLEN       = WB_XLEN,
  parameter int unsigned DEPTH      = WB_LATE_DEPTH,
  parameter int unsigned STARVE_MAX = WB_STARVE_MAX
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       pipe_we_i,
  input  logic [4:0]                 pipe_rd_i,
  input  logic [XLEN-1:0]            pipe_data_i,
  input  logic                       late_valid_i,
  output logic                       late_ready_o,
  input  logic [4:0]                 late_rd_i,
  input  logic [XLEN-1:0]            late_data_i,
  input  logic [4:0]                 rs1_addr_i,
  input  logic [4:0]                 rs2_addr_i,
  output logic                       rs1_pending_o,
  output logic                       rs2_pending_o,
  output logic                       drain_stall_o,
  output logic                       rf_we_o,
  output logic [4:0]                 rf_rd_o,
  output logic [XLEN-1:0]            rf_data_o,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count_o
);

  localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);

  wb_late_entry_t   push_entry, head;
  logic             pipe_act, push, pop, head_valid, head_live, drain_wins, full;
  logic             rs1_match, rs2_match;
  logic             drain_stall_q, drain_stall_d;
  logic [StarveW-1:0] starve_q, starve_d;

  assign pipe_act     = pipe_we_i && (pipe_rd_i != 5'd0);
  assign late_ready_o = !full;
  // x0 results complete the handshake but are never buffered.
  assign push         = late_valid_i && late_ready_o && (late_rd_i != 5'd0);
  // A late op is older than a same-cycle pipeline write to the same rd, so it lands dead.
  assign push_entry   = '{live: !(pipe_act && (pipe_rd_i == late_rd_i)),
                          rd:   late_rd_i,
                          data: late_data_i};

  wb_late_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk_i),
    .rst        (rst_i),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .kill_en    (pipe_act),
    .kill_rd    (pipe_rd_i),
    .rs1        (rs1_addr_i),
    .rs2        (rs2_addr_i),
    .head       (head),
    .head_valid (head_valid),
    .full       (full),
    .count      (fifo_count_o),
    .rs1_match  (rs1_match),
    .rs2_match  (rs2_match)
  );

  assign head_live  = head_valid && head.live;
  assign drain_wins = head_live && (drain_stall_q || !pipe_act);
  // Killed heads retire silently in any cycle, independent of who owns the port.
  assign pop        = drain_wins || (head_valid && !head.live);

  always_comb begin
    rf_we_o   = 1'b0;
    rf_rd_o   = 5'd0;
    rf_data_o = '0;
    if (drain_wins) begin
      rf_we_o   = 1'b1;
      rf_rd_o   = head.rd;
      rf_data_o = head.data;
    end else if (pipe_act) begin
      rf_we_o   = 1'b1;
      rf_rd_o   = pipe_rd_i;
      rf_data_o = pipe_data_i;
    end
  end

  always_comb begin
    starve_d      = starve_q;
    drain_stall_d = 1'b0;
    if (!head_valid || pop) begin
      starve_d = '0;
    end else if (head_live) begin
      if (starve_q == StarveW'(STARVE_MAX - 1)) begin
        starve_d      = '0;
        drain_stall_d = 1'b1;
      end else begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q      <= '0;
      drain_stall_q <= 1'b0;
    end else begin
      starve_q      <= starve_d;
      drain_stall_q <= drain_stall_d;
    end
  end

  assign drain_stall_o = drain_stall_q;

  // A popped head still counts: decode reads the RF only on the next cycle.
  assign rs1_pending_o = (rs1_addr_i != 5'd0) &&
                         (rs1_match || (push && (late_rd_i == rs1_addr_i)));
  assign rs2_pending_o = (rs2_addr_i != 5'd0) &&
                         (rs2_match || (push && (late_rd_i == rs2_addr_i)));

  no_pipe_write_in_drain : assert property (
    @(posedge clk_i) disable iff (rst_i) drain_stall_q |-> !pipe_we_i
  );

endmodule
